// File: rtl/prio_arbiter_n.sv
// Registered N-way priority arbiter: fixed (MSB highest) or round-robin selection,
// presented as index + one-hot under a valid/ready handshake.
module prio_arbiter_n #(
    parameter int unsigned N = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 mode,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic [N-1:0]         grant_onehot,
    output logic                 any_req
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   idx_q;
    logic [N-1:0]    onehot_q;

    logic [IW-1:0]   base;
    logic [IW-1:0]   cand;
    logic            found;
    logic [IW-1:0]   win_idx_d;
    logic [N-1:0]    win_oh_d;
    logic            load;

    assign any_req = |req;
    assign load    = (state_q == IDLE) || out_ready;

    // Search base-1, base-2, ... base (mod N); fixed mode is round-robin with base 0.
    always_comb begin
        base      = mode ? last_q : '0;
        cand      = '0;
        found     = 1'b0;
        win_idx_d = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = base - IW'(k);
            if (!found && req[cand]) begin
                win_idx_d = cand;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        win_oh_d            = '0;
        win_oh_d[win_idx_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
        end else if (load) begin
            if (|req) begin
                state_q  <= HOLD;
                idx_q    <= win_idx_d;
                onehot_q <= win_oh_d;
                last_q   <= win_idx_d;
            end else begin
                state_q  <= IDLE;
            end
        end
    end

    assign out_valid    = (state_q == HOLD);
    assign grant_idx    = idx_q;
    assign grant_onehot = onehot_q;

endmodule

// File: tb/tb_prio_arbiter_n.sv
// Directed scoreboard bench for prio_arbiter_n at N=16 and N=4.
module tb_prio_arbiter_n;

    typedef struct packed {
        logic        v;
        logic [3:0]  idx;
        logic [15:0] oh;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst16, mode16, rdy16;
    logic [15:0] req16;
    logic        valid16, any16;
    logic [3:0]  idx16;
    logic [15:0] oh16;

    logic        rst4, mode4, rdy4;
    logic [3:0]  req4;
    logic        valid4, any4;
    logic [1:0]  idx4;
    logic [3:0]  oh4;

    prio_arbiter_n #(.N(16)) u16 (
        .clk(clk), .reset(rst16), .req(req16), .mode(mode16), .out_ready(rdy16),
        .out_valid(valid16), .grant_idx(idx16), .grant_onehot(oh16), .any_req(any16)
    );

    prio_arbiter_n #(.N(4)) u4 (
        .clk(clk), .reset(rst4), .req(req4), .mode(mode4), .out_ready(rdy4),
        .out_valid(valid4), .grant_idx(idx4), .grant_onehot(oh4), .any_req(any4)
    );

    exp_t sb16[$];
    exp_t sb4[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step16(input string tag, input logic rst, input logic m, input logic rdy,
                          input logic [15:0] r, input logic ev, input int unsigned ei,
                          input logic [15:0] eo);
        exp_t e;
        rst16 = rst; mode16 = m; rdy16 = rdy; req16 = r;
        e.v = ev; e.idx = 4'(ei); e.oh = eo;
        sb16.push_back(e);
        #1 check({tag, "/any"}, 32'(any16), 32'(|r));
        @(posedge clk); #1;
        e = sb16.pop_front();
        check({tag, "/valid"}, 32'(valid16), 32'(e.v));
        check({tag, "/idx"},   32'(idx16),   32'(e.idx));
        check({tag, "/oh"},    32'(oh16),    32'(e.oh));
    endtask

    task automatic step4(input string tag, input logic rst, input logic m, input logic rdy,
                         input logic [3:0] r, input logic ev, input int unsigned ei,
                         input logic [3:0] eo);
        exp_t e;
        rst4 = rst; mode4 = m; rdy4 = rdy; req4 = r;
        e.v = ev; e.idx = 4'(ei); e.oh = 16'(eo);
        sb4.push_back(e);
        #1 check({tag, "/any"}, 32'(any4), 32'(|r));
        @(posedge clk); #1;
        e = sb4.pop_front();
        check({tag, "/valid"}, 32'(valid4), 32'(e.v));
        check({tag, "/idx"},   32'(idx4),   32'(e.idx));
        check({tag, "/oh"},    32'(oh4),    32'(e.oh));
    endtask

    initial begin
        rst16 = 1'b1; mode16 = 1'b0; rdy16 = 1'b0; req16 = '0;
        rst4  = 1'b1; mode4  = 1'b0; rdy4  = 1'b0; req4  = '0;
        @(posedge clk); #1;

        // N=16 fixed priority
        step16("rst",      1, 0, 0, 16'h0000, 0, 0,  16'h0000);
        step16("idle0",    0, 0, 0, 16'h0000, 0, 0,  16'h0000);
        step16("idle1",    0, 0, 1, 16'h0000, 0, 0,  16'h0000);
        step16("idle2",    0, 0, 0, 16'h0000, 0, 0,  16'h0000);
        step16("fix11",    0, 0, 1, 16'h0912, 1, 11, 16'h0800);
        for (int i = 0; i < 4; i++)
            step16("hold",  0, 0, 0, 16'h8000, 1, 11, 16'h0800);
        step16("acc15",    0, 0, 1, 16'h8000, 1, 15, 16'h8000);
        step16("drain",    0, 0, 1, 16'h0000, 0, 15, 16'h8000);
        step16("drain2",   0, 0, 1, 16'h0000, 0, 15, 16'h8000);

        // Round-robin from reset (last=0)
        step16("rst2",     1, 1, 1, 16'h0912, 0, 0,  16'h0000);
        step16("rr11a",    0, 1, 1, 16'h0912, 1, 11, 16'h0800);
        step16("rr8a",     0, 1, 1, 16'h0912, 1, 8,  16'h0100);
        step16("rr4",      0, 1, 1, 16'h0912, 1, 4,  16'h0010);
        step16("rr1",      0, 1, 1, 16'h0912, 1, 1,  16'h0002);
        step16("rr11b",    0, 1, 1, 16'h0912, 1, 11, 16'h0800);
        step16("rr8b",     0, 1, 1, 16'h0912, 1, 8,  16'h0100);
        for (int i = 0; i < 3; i++)
            step16("fixrep", 0, 0, 1, 16'h0912, 1, 11, 16'h0800);

        // Reset mid round-robin clears last
        step16("rst3",     1, 1, 1, 16'h0912, 0, 0,  16'h0000);
        step16("rr11c",    0, 1, 1, 16'h0912, 1, 11, 16'h0800);
        step16("rr8c",     0, 1, 1, 16'h0912, 1, 8,  16'h0100);
        step16("rstmid",   1, 1, 1, 16'h0912, 0, 0,  16'h0000);
        step16("rr11d",    0, 1, 1, 16'h0912, 1, 11, 16'h0800);
        step16("rr8d",     0, 1, 1, 16'h0912, 1, 8,  16'h0100);
        step16("rsthold",  1, 1, 0, 16'h0912, 0, 0,  16'h0000);
        step16("rrwrap",   0, 1, 1, 16'h0001, 1, 0,  16'h0001);
        step16("rrlast",   0, 1, 1, 16'h8001, 1, 15, 16'h8000);

        // N=4
        step4("n4rst",     1, 0, 0, 4'b0000, 0, 0, 4'b0000);
        step4("n4fix",     0, 0, 1, 4'b0101, 1, 2, 4'b0100);
        step4("n4rst2",    1, 1, 1, 4'b1001, 0, 0, 4'b0000);
        step4("n4rr3a",    0, 1, 1, 4'b1001, 1, 3, 4'b1000);
        step4("n4rr0a",    0, 1, 1, 4'b1001, 1, 0, 4'b0001);
        step4("n4rr3b",    0, 1, 1, 4'b1001, 1, 3, 4'b1000);
        step4("n4rr0b",    0, 1, 1, 4'b1001, 1, 0, 4'b0001);

        check("sb16empty", 32'(sb16.size()), 32'd0);
        check("sb4empty",  32'(sb4.size()),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
